// File: rtl/rmii_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// rmii_tx_serializer_if
//
// Purpose: bundles the upstream byte stream and the RMII TX pin signals of
// rmii_tx_serializer into one interface.
//
// Signals:
//   axiiv     upstream byte valid
//   axiid     upstream byte (8 bits)
//   axiilast  axiid is the final byte of the frame
//   axiir     serializer ready for a byte
//   txen      RMII TX_EN
//   txd       RMII TXD[1:0]
//   underrun  one-cycle pulse when a frame is cut short for lack of data
//
// Handshake: a byte transfers on a rising clk edge where axiiv && axiir.
// The source may raise axiiv at any time and must hold axiid/axiilast stable
// while axiiv is high and no transfer has happened; the serializer may drop
// axiir at any time without waiting for axiiv. axiid/axiilast are
// don't-care while axiiv is low.
//
// Modports:
//   master  byte source / pin observer (frame builder side)
//   slave   the serializer itself
// ---------------------------------------------------------------------------
interface rmii_tx_serializer_if;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiilast;
    logic       axiir;
    logic       txen;
    logic [1:0] txd;
    logic       underrun;

    modport master (
        output axiiv, axiid, axiilast,
        input  axiir, txen, txd, underrun
    );

    modport slave (
        input  axiiv, axiid, axiilast,
        output axiir, txen, txd, underrun
    );
endinterface

// File: rtl/rmii_tx_serializer.sv
// ---------------------------------------------------------------------------
// rmii_tx_serializer
//
// Purpose: turns a valid/ready byte stream into RMII TX dibits (LSB dibit
// first, one byte per 4 clk cycles) with TX_EN framing. Each frame is
// optionally preceded by preamble + SFD and is always followed by an
// inter-packet gap during which no new byte is accepted. If upstream fails
// to supply the next byte of an unfinished frame in time, the frame is
// truncated and underrun pulses for one cycle.
//
// Build option: define RMII_TX_PREAMBLE_EN to insert PREAMBLE_BYTES x 0x55
// plus the SFD 0xD5 ahead of every frame. Without it, the first payload
// dibit goes out the cycle after acceptance and upstream supplies any
// preamble itself.
//
// Ports:
//   clk        RMII reference clock (50 MHz)
//   rst        synchronous, active-high reset
//   bus        rmii_tx_serializer_if.slave (byte stream in, RMII pins out)
//   fsm_state  current FSM state encoding, for debug/observation
//
// Parameters:
//   PREAMBLE_BYTES  number of 0x55 bytes before the SFD
//   IFG_CYCLES      txen-low cycles enforced after each frame
// ---------------------------------------------------------------------------
module rmii_tx_serializer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_CYCLES     = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    rmii_tx_serializer_if.slave  bus,
    output logic [1:0]           fsm_state
);

    localparam int PRE_DIBITS = PREAMBLE_BYTES * 4 + 4;
    localparam int MAX_COUNT  = (PRE_DIBITS > IFG_CYCLES) ? PRE_DIBITS : IFG_CYCLES;
    localparam int CNT_W      = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
`ifdef RMII_TX_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_DIBITS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
`ifdef RMII_TX_PREAMBLE_EN
        PREAMBLE = 2'd1,
`endif
        PAYLOAD  = 2'd2,
        IFG      = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;      // preamble dibit / IFG cycle count
    logic [1:0]       idx, idx_n;      // dibit index within the held byte
    logic [7:0]       byte_q, byte_n;  // byte being shifted out
    logic             last_q, last_n;  // held byte ends the frame

    logic             accept;
    logic             txen_n;
    logic [1:0]       txd_n;
    logic             axiir_n;
    logic             underrun_n;

    assign fsm_state = state;
    assign accept    = bus.axiiv && bus.axiir;

    // Next-state logic. The outputs below are derived from the *next* state
    // so that every pin is a flop yet still lines up with the state it
    // belongs to.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        byte_n     = byte_q;
        last_n     = last_q;
        underrun_n = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    byte_n = bus.axiid;
                    last_n = bus.axiilast;
                    cnt_n  = '0;
                    idx_n  = 2'd0;
`ifdef RMII_TX_PREAMBLE_EN
                    state_n = PREAMBLE;
`else
                    state_n = PAYLOAD;
`endif
                end
            end

`ifdef RMII_TX_PREAMBLE_EN
            PREAMBLE: begin
                if (cnt == PRE_LAST) begin
                    state_n = PAYLOAD;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif

            PAYLOAD: begin
                if (idx != 2'd3) begin
                    idx_n = idx + 2'd1;
                end else if (last_q) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end else if (accept) begin
                    // Back-to-back byte: starts at index 0 next cycle, txen
                    // stays high across the byte boundary.
                    byte_n = bus.axiid;
                    last_n = bus.axiilast;
                    idx_n  = 2'd0;
                end else begin
                    // Upstream starved an unfinished frame: cut it here.
                    underrun_n = 1'b1;
                    state_n    = IFG;
                    cnt_n      = '0;
                end
            end

            IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = 2'd0;
            end
        endcase

        txen_n  = 1'b0;
        txd_n   = 2'b00;
        axiir_n = 1'b0;

        case (state_n)
            IDLE: begin
                axiir_n = 1'b1;
            end
`ifdef RMII_TX_PREAMBLE_EN
            PREAMBLE: begin
                // 0x55 and the first three SFD dibits are all 01; only the
                // final SFD dibit (top of 0xD5) differs.
                txen_n = 1'b1;
                txd_n  = (cnt_n == PRE_LAST) ? 2'b11 : 2'b01;
            end
`endif
            PAYLOAD: begin
                txen_n  = 1'b1;
                axiir_n = (idx_n == 2'd3) && !last_n;
                case (idx_n)
                    2'd0:    txd_n = byte_n[1:0];
                    2'd1:    txd_n = byte_n[3:2];
                    2'd2:    txd_n = byte_n[5:4];
                    default: txd_n = byte_n[7:6];
                endcase
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= 2'd0;
            byte_q       <= 8'h00;
            last_q       <= 1'b0;
            bus.txen     <= 1'b0;
            bus.txd      <= 2'b00;
            bus.axiir    <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            byte_q       <= byte_n;
            last_q       <= last_n;
            bus.txen     <= txen_n;
            bus.txd      <= txd_n;
            bus.axiir    <= axiir_n;
            bus.underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_rmii_tx_serializer
//
// Drives frames into rmii_tx_serializer and checks the RMII dibit stream,
// frame lengths, underrun pulses, inter-packet gap and reset behaviour.
// Expected dibits are built from the frame bytes (plus preamble/SFD when
// RMII_TX_PREAMBLE_EN is defined) and queued when a byte is handed over.
// ---------------------------------------------------------------------------
module tb_rmii_tx_serializer;

`ifdef RMII_TX_PREAMBLE_EN
    localparam int PRE = 32;   // 7 x 0x55 + 0xD5, four dibits each
`else
    localparam int PRE = 0;
`endif
    localparam int IFG = 48;

    logic clk;
    logic rst;
    logic [1:0] fsm_state;

    rmii_tx_serializer_if bus ();

    rmii_tx_serializer #(
        .PREAMBLE_BYTES(7),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
    endtask

    task automatic push_preamble();
        if (PRE > 0) begin
            for (int i = 0; i < 7; i++) push_byte(8'h55);
            push_byte(8'hD5);
        end
    endtask

    // Dibit monitor: every txen-high cycle consumes one expected dibit;
    // txd must be 00 whenever txen is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.txen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txd_unexpected: txd=%b with no dibit expected (cycle %0d)", bus.txd, cyc);
                end else begin
                    chk("txd", {30'd0, bus.txd}, {30'd0, exp_q.pop_front()});
                end
            end else begin
                chk("idle_txen_txd", {29'd0, bus.txen, bus.txd}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are read 1 ns after the
    // falling edge, well away from the rising (active) edge.
    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        int         n;
        logic [7:0] d[4];
        int         stall;    // index of last byte supplied before starving, -1 = none
        int         exp_len;  // txen-high cycles
        logic       exp_und;
    } vec_t;

    vec_t vec[5];

    // Hand a frame to the DUT; returns once txen drops (first IFG cycle).
    task automatic send_frame(input vec_t v, output int len, output logic und);
        int t0;
        int nsend;
        int b;
        nsend = (v.stall >= 0) ? v.stall + 1 : v.n;
        t0 = cyc;
        len = 0;
        und = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            b = 0;
            while (bus.axiir !== 1'b1 && b < 100) begin
                tick();
                b++;
            end
            if (b >= 100) begin
                chk("axiir_wait_timeout", 32'(b), 32'd0);
                break;
            end
            if (i == 0) push_preamble();
            push_byte(v.d[i]);
            bus.axiiv    = 1'b1;
            bus.axiid    = v.d[i];
            bus.axiilast = (i == v.n - 1);
            tick();
            if (i == 0) t0 = cyc;
            bus.axiiv    = 1'b0;
            bus.axiid    = 8'($urandom_range(0, 255));
            bus.axiilast = 1'($urandom_range(0, 1));
        end
        b = 0;
        while (bus.txen === 1'b1 && b < 400) begin
            tick();
            b++;
        end
        len = cyc - t0;
        und = bus.underrun;
    endtask

    // Counts axiir-low cycles from the first IFG cycle until IDLE.
    task automatic wait_ifg(output int n, output logic glitch);
        n = 0;
        glitch = 1'b0;
        while (bus.axiir !== 1'b1 && n < 200) begin
            if (n > 0 && bus.underrun === 1'b1) glitch = 1'b1;
            if (bus.txen === 1'b1) glitch = 1'b1;
            tick();
            n++;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int len;
        int ifg_n;
        int low;
        int ir;
        int b;
        logic und;
        logic glitch;

        vec[0].n = 1; vec[0].d = '{8'hA5, 8'h00, 8'h00, 8'h00};
        vec[0].stall = -1; vec[0].exp_len = PRE + 4;  vec[0].exp_und = 1'b0;
        vec[1].n = 2; vec[1].d = '{8'h12, 8'h34, 8'h00, 8'h00};
        vec[1].stall = -1; vec[1].exp_len = PRE + 8;  vec[1].exp_und = 1'b0;
        vec[2].n = 2; vec[2].d = '{8'h12, 8'h34, 8'h00, 8'h00};
        vec[2].stall = 0;  vec[2].exp_len = PRE + 4;  vec[2].exp_und = 1'b1;
        vec[3].n = 4; vec[3].d = '{8'h00, 8'hFF, 8'hC3, 8'h5A};
        vec[3].stall = -1; vec[3].exp_len = PRE + 16; vec[3].exp_und = 1'b0;
        vec[4].n = 3;
        for (int k = 0; k < 4; k++) vec[4].d[k] = 8'($urandom_range(0, 255));
        vec[4].stall = 1;  vec[4].exp_len = PRE + 8;  vec[4].exp_und = 1'b1;

        bus.axiiv = 1'b0;
        bus.axiid = 8'h00;
        bus.axiilast = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        mon_en = 1'b1;

        // reset state
        chk("reset_axiir", {31'd0, bus.axiir}, 32'd0);
        chk("reset_txen", {31'd0, bus.txen}, 32'd0);
        chk("reset_txd", {30'd0, bus.txd}, 32'd0);
        chk("reset_underrun", {31'd0, bus.underrun}, 32'd0);
        rst = 1'b0;
        tick();
        chk("axiir_after_reset", {31'd0, bus.axiir}, 32'd1);

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            send_frame(vec[v], len, und);
            chk($sformatf("vec%0d_txen_len", v), 32'(len), 32'(vec[v].exp_len));
            chk($sformatf("vec%0d_underrun", v), {31'd0, und}, {31'd0, vec[v].exp_und});
            wait_ifg(ifg_n, glitch);
            chk($sformatf("vec%0d_ifg_len", v), 32'(ifg_n), 32'(IFG));
            chk($sformatf("vec%0d_ifg_glitch", v), {31'd0, glitch}, 32'd0);
            chk($sformatf("vec%0d_queue_empty", v), 32'(exp_q.size()), 32'd0);
        end

        // reset in the middle of the payload (index 1)
        b = 0;
        while (bus.axiir !== 1'b1 && b < 100) begin tick(); b++; end
        push_preamble();
        push_byte(8'h12);
        bus.axiiv = 1'b1;
        bus.axiid = 8'h12;
        bus.axiilast = 1'b0;
        tick();
        bus.axiiv = 1'b0;
        for (int k = 0; k < PRE + 1; k++) tick();
        chk("mid_payload_txen", {31'd0, bus.txen}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("rst_mid_txen", {31'd0, bus.txen}, 32'd0);
        chk("rst_mid_txd", {30'd0, bus.txd}, 32'd0);
        chk("rst_mid_axiir", {31'd0, bus.axiir}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_mid_axiir_release", {31'd0, bus.axiir}, 32'd1);
        send_frame(vec[0], len, und);
        chk("post_rst_txen_len", 32'(len), 32'(PRE + 4));

        // axiiv held high with 0xFF through the whole IFG
        bus.axiiv = 1'b1;
        bus.axiid = 8'hFF;
        bus.axiilast = 1'b1;
        push_preamble();
        push_byte(8'hFF);
        low = 0;
        ir = 0;
        while (bus.txen !== 1'b1 && low < 200) begin
            if (bus.axiir === 1'b1) ir++;
            tick();
            low++;
        end
        bus.axiiv = 1'b0;
        chk("held_ifg_low_cycles", 32'(low), 32'(IFG + 1));
        chk("held_ifg_ready_cycles", 32'(ir), 32'd1);
        b = 0;
        len = 0;
        while (bus.txen === 1'b1 && b < 400) begin tick(); b++; len++; end
        chk("held_frame_txen_len", 32'(len), 32'(PRE + 4));
        wait_ifg(ifg_n, glitch);
        chk("held_frame_ifg_len", 32'(ifg_n), 32'(IFG));

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmii_tx_serializer.md
Name: rmii_tx_serializer

Overview:
- Transmit-side counterpart of the RMII receive dibit reorder path.
- Accepts payload bytes over a valid/ready byte stream and emits RMII TX dibits, LSB dibit first, with txen framing.
- Inserts preamble and SFD ahead of each frame and enforces the inter-packet gap after it.
- Sits between the frame builder (upstream byte source) and the RMII PHY TX pins; one byte takes 4 clk cycles on the wire.

Parameters:
- PREAMBLE_BYTES, 7, number of 0x55 bytes sent before the SFD (0xD5).
- IFG_CYCLES, 48, txen-low cycles after each frame (12 byte times).

Ports:
- clk  input  1  RMII reference clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- axiiv  input  1  upstream byte valid.
- axiid  input  8  upstream byte.
- axiilast  input  1  qualifies axiid as the final byte of the frame.
- axiir  output  1  ready; a byte is accepted on a clk edge where axiiv && axiir.
- txen  output  1  RMII TX_EN.
- txd  output  2  RMII TXD[1:0].
- underrun  output  1  one-cycle pulse when a frame is aborted for lack of data.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: txen=0, txd=2'b00, axiir=0, underrun=0, state=IDLE, byte register=0, dibit index=0, counters=0.
- axiir rises one cycle after rst deasserts.
- Reset mid-frame: txen=0 and txd=00 on the next edge, no trailing dibits, no IFG enforced.
- Dibit order per byte, in successive cycles: [1:0], [3:2], [5:4], [7:6].
- txd=00 whenever txen=0.
- IDLE:
  - axiir=1.
  - On accept: latch axiid and axiilast, axiir=0, go to PREAMBLE.
  - txen rises on the edge after acceptance, i.e. 1 cycle latency.
- PREAMBLE:
  - Sends PREAMBLE_BYTES*4 dibits of 2'b01, then the SFD dibits 01,01,01,11.
  - axiir=0 throughout; the latched first byte is held.
  - After the last SFD dibit, go to PAYLOAD at dibit index 0.
- PAYLOAD:
  - Shifts out the held byte over indices 0..3.
  - axiir=1 only during index 3, and only if the held byte is not last.
  - Accept at index 3: the new byte is sent from index 0 in the next cycle, so txen stays continuous.
  - Index 3 with held byte last: go to IFG; txen=0 on the next cycle.
  - Index 3, held byte not last, no accept: underrun. txen=0 next cycle, underrun=1 for exactly that cycle, go to IFG.
  - The frame is truncated; no padding or partial byte is sent.
- IFG:
  - txen=0, axiir=0 for IFG_CYCLES cycles; axiiv is ignored.
  - Then IDLE, with axiir=1 in the first IDLE cycle.
- Single-byte frame (axiilast on the IDLE accept): preamble+SFD, 4 payload dibits, IFG.
- Counter widths are sized by $clog2 of the largest count: PREAMBLE_BYTES*4+4 and IFG_CYCLES.
- axiid and axiilast are don't-care when axiiv=0.

Optional Feature:
- Macro: RMII_TX_PREAMBLE_EN.
- Defined: PREAMBLE state present; behaviour exactly as above.
- Undefined:
  - PREAMBLE state removed; an IDLE accept goes straight to PAYLOAD.
  - First payload dibit appears on txd the cycle after acceptance.
  - Upstream must then supply preamble and SFD bytes itself.
  - All other behaviour (IFG, underrun, reset) is unchanged.

Test Plan:
- Macro on: accept 0xA5 with last at cycle T
  - -> txen=1 for T+1..T+36; txd is 28x01, then 01,01,01,11, then 01,01,10,10.
  - -> txen=0 for T+37..T+84; axiir=1 at T+85.
- Macro on, bytes 0x12 then 0x34(last), second byte presented at index 3
  - -> payload txd 10,00,01,00,00,01,11,00.
  - -> txen never drops between bytes; total txen length 40 cycles.
- Underrun: 0x12 (not last), axiiv=0 at index 3
  - -> txen=0 on the next cycle with underrun=1 for that single cycle.
  - -> 48 idle cycles, then axiir=1.
- Reset mid-payload (rst=1 at payload index 1)
  - -> txen=0, txd=00, axiir=0 next edge; axiir=1 one cycle after rst deasserts.
  - -> a fresh frame then starts with its full preamble.
- axiiv=1 held through IFG with byte 0xFF
  - -> no accept, txen stays 0 for all 48 cycles; accepted on the first IDLE cycle.
- Macro off: accept 0xA5 with last at T
  - -> txen=1 for T+1..T+4 with txd 01,01,10,10.
  - -> txen=0 for T+5..T+52; axiir=1 at T+53.
